// File: rtl/gaussian_arbiter.sv
// Shares one gaussian noise generator between NUM_REQ requesters.
// Sequences seed load, warm-up discard, then round-robin sample service.
module gaussian_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int FRACTIONAL_BITS = 24,
  parameter int NUM_REQ         = 4,
  parameter int WARMUP          = 16,
  parameter logic [FRACTIONAL_BITS:0] DEFAULT_SEED = 25'h1DCB000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       cfg_load,
  input  logic [FRACTIONAL_BITS:0]   cfg_seed,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [DATA_WIDTH-1:0]      sample_out,
  output logic                       ready,
  output logic [31:0]                sample_count,
  output logic                       gen_enable,
  output logic                       gen_seed_load,
  output logic [FRACTIONAL_BITS:0]   gen_seed,
  input  logic [DATA_WIDTH-1:0]      gen_randnum
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [1:0] SEED  = 2'd0;
  localparam logic [1:0] WARM  = 2'd1;
  localparam logic [1:0] SERVE = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [WW-1:0]            warm_q, warm_d;
  logic [PW-1:0]            rr_q, rr_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [31:0]              cnt_q, cnt_d;
  logic [FRACTIONAL_BITS:0] seed_q, seed_d;

  logic [PW-1:0] win;
  logic [PW-1:0] idx_v;
  logic          hit;

  // First set request strictly after the pointer, wrapping around.
  always_comb begin
    win   = rr_q;
    hit   = 1'b0;
    idx_v = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_v = PW'((int'(rr_q) + i) % NUM_REQ);
      if (!hit && req[idx_v]) begin
        hit = 1'b1;
        win = idx_v;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    unique case (state_q)
      SEED: begin
        cnt_d   = '0;
        warm_d  = WW'(WARMUP);
        state_d = (WARMUP == 0) ? SERVE : WARM;
      end
      WARM: begin
        warm_d = warm_q - WW'(1);
        if (warm_q == WW'(1)) state_d = SERVE;
      end
      SERVE: begin
        if (hit) begin
          rr_d  = win;
          gnt_d = NUM_REQ'(1) << win;
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = SEED;
    endcase
    // A reseed pre-empts arbitration and warm-up in the same cycle.
    if (cfg_load) begin
      state_d = SEED;
      seed_d  = cfg_seed;
      warm_d  = warm_q;
      rr_d    = rr_q;
      gnt_d   = '0;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= SEED;
      warm_q  <= '0;
      rr_q    <= PW'(NUM_REQ - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
      seed_q  <= DEFAULT_SEED;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
    end
  end

  assign gnt           = gnt_q;
  assign sample_out    = gen_randnum;
  assign ready         = (state_q == SERVE);
  assign sample_count  = cnt_q;
  assign gen_seed      = seed_q;
  // Reset holds state at SEED, so the strobe is masked while it is asserted.
  assign gen_seed_load = !Reset && (state_q == SEED);
  assign gen_enable    = !cfg_load &&
                         ((state_q == WARM) ||
                          ((state_q == SERVE) && (|req)));

endmodule

// File: tb/tb_gaussian_arbiter.sv
// Bench for gaussian_arbiter: behavioural model plus directed
// literal checks, then randomized request/reseed/reset traffic.
module tb_gaussian_arbiter;

  localparam int NR = 4;
  localparam logic [24:0] DEF = 25'h1DCB000;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          cfg_load;
  logic [24:0]   cfg_seed;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [31:0]   sample_out;
  logic          ready;
  logic [31:0]   sample_count;
  logic          gen_enable;
  logic          gen_seed_load;
  logic [24:0]   gen_seed;
  logic [31:0]   gen_randnum = 32'h1234_5678;

  logic [NR-1:0] gnt0;
  logic [31:0]   sample_out0;
  logic          ready0;
  logic [31:0]   sample_count0;
  logic          gen_enable0;
  logic          gen_seed_load0;
  logic [24:0]   gen_seed0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  gaussian_arbiter dut (
    .Clk(Clk), .Reset(Reset), .cfg_load(cfg_load),
    .cfg_seed(cfg_seed), .req(req), .gnt(gnt),
    .sample_out(sample_out), .ready(ready),
    .sample_count(sample_count), .gen_enable(gen_enable),
    .gen_seed_load(gen_seed_load), .gen_seed(gen_seed),
    .gen_randnum(gen_randnum)
  );

  gaussian_arbiter #(.WARMUP(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .cfg_load(cfg_load),
    .cfg_seed(cfg_seed), .req(req), .gnt(gnt0),
    .sample_out(sample_out0), .ready(ready0),
    .sample_count(sample_count0), .gen_enable(gen_enable0),
    .gen_seed_load(gen_seed_load0), .gen_seed(gen_seed0),
    .gen_randnum(gen_randnum)
  );

  // Stand-in generator: new random value after each enabled edge.
  always @(posedge Clk)
    if (gen_enable) gen_randnum <= $urandom;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, warm cycles left, pointer,
  // pending grant index, delivered count, current seed.
  int          m_mode;
  int          m_warm;
  int          m_rr;
  int          m_pend;
  int          m_win;
  int          m_j;
  logic [31:0] m_cnt;
  logic [24:0] m_seed;
  logic [NR-1:0] e_gnt;
  logic        e_en;

  always @(negedge Clk) begin
    if (Reset) begin
      m_mode = 0;
      m_rr   = NR - 1;
      m_pend = -1;
      m_cnt  = 0;
      m_seed = DEF;
    end
    e_gnt = (m_pend >= 0) ? NR'(1 << m_pend) : '0;
    e_en  = !Reset && !cfg_load &&
            (m_mode == 1 || (m_mode == 2 && req != 0));
    chk("m_gnt", 64'(gnt), 64'(e_gnt));
    chk("m_ready", 64'(ready), 64'(m_mode == 2));
    chk("m_seedld", 64'(gen_seed_load),
        64'(!Reset && m_mode == 0));
    chk("m_en", 64'(gen_enable), 64'(e_en));
    chk("m_count", 64'(sample_count), 64'(m_cnt));
    chk("m_seed", 64'(gen_seed), 64'(m_seed));
    if (m_pend >= 0)
      chk("m_sample", 64'(sample_out), 64'(gen_randnum));
    if (!Reset) begin
      m_win = -1;
      for (int i = 1; i <= NR; i++) begin
        m_j = (m_rr + i) % NR;
        if (m_win < 0 && req[m_j]) m_win = m_j;
      end
      m_pend = -1;
      if (cfg_load) begin
        m_seed = cfg_seed;
        m_mode = 0;
      end else if (m_mode == 0) begin
        m_cnt  = 0;
        m_warm = 16;
        m_mode = 1;
      end else if (m_mode == 1) begin
        m_warm = m_warm - 1;
        if (m_warm == 0) m_mode = 2;
      end else if (m_win >= 0) begin
        m_rr   = m_win;
        m_pend = m_win;
        m_cnt  = m_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Entered one step into the SEED cycle; leaves one step into
  // the first SERVE cycle after checking it.
  task automatic boot_check(input logic [24:0] s, input bit chk0);
    @(negedge Clk);
    chk("seed_ld", 64'(gen_seed_load), 64'd1);
    chk("seed_val", 64'(gen_seed), 64'(s));
    chk("seed_en", 64'(gen_enable), 64'd0);
    step();
    for (int k = 0; k < 16; k++) begin
      @(negedge Clk);
      chk("warm_en", 64'(gen_enable), 64'd1);
      chk("warm_rdy", 64'(ready), 64'd0);
      chk("warm_gnt", 64'(gnt), 64'd0);
      if (k == 0) chk("warm_cnt", 64'(sample_count), 64'd0);
      if (chk0 && k == 0) begin
        chk("w0_ready", 64'(ready0), 64'd1);
        chk("w0_en", 64'(gen_enable0), 64'd0);
        chk("w0_gnt", 64'(gnt0), 64'd0);
      end
      step();
    end
    @(negedge Clk);
    chk("serve_rdy", 64'(ready), 64'd1);
    chk("serve_gnt", 64'(gnt), 64'd0);
    step();
  endtask

  initial begin
    Reset    = 1'b1;
    cfg_load = 1'b0;
    cfg_seed = '0;
    req      = '0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_seedld", 64'(gen_seed_load), 64'd0);
    repeat (3) step();
    Reset = 1'b0;
    boot_check(DEF, 1'b1);

    // All four requesting: pure rotation from requester 0.
    for (int k = 0; k <= 8; k++) begin
      req = (k < 8) ? 4'b1111 : 4'b0000;
      @(negedge Clk);
      if (k >= 1)
        chk("rot_gnt", 64'(gnt), 64'(4'b0001 << ((k - 1) % 4)));
      step();
    end

    // Single requester held for three launch cycles.
    req = '0;
    step();
    for (int k = 0; k <= 3; k++) begin
      req = (k < 3) ? 4'b0100 : 4'b0000;
      @(negedge Clk);
      chk("one_gnt", 64'(gnt), (k == 0) ? 64'd0 : 64'd4);
      chk("one_en", 64'(gen_enable), 64'(k < 3));
      if (k == 3) chk("one_cnt", 64'(sample_count), 64'd11);
      step();
    end

    // Launch, then reseed the next cycle: grant still delivered.
    req = 4'b0001;
    step();
    cfg_load = 1'b1;
    cfg_seed = 25'h0ABCDE;
    @(negedge Clk);
    chk("cfg_gnt", 64'(gnt), 64'd1);
    chk("cfg_en", 64'(gen_enable), 64'd0);
    step();
    cfg_load = 1'b0;
    req      = '0;
    boot_check(25'h0ABCDE, 1'b0);

    // Reset asserted partway through warm-up.
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    repeat (6) step();
    Reset = 1'b1;
    #1;
    chk("ar_gnt", 64'(gnt), 64'd0);
    chk("ar_rdy", 64'(ready), 64'd0);
    chk("ar_en", 64'(gen_enable), 64'd0);
    chk("ar_seedld", 64'(gen_seed_load), 64'd0);
    chk("ar_cnt", 64'(sample_count), 64'd0);
    chk("ar_seed", 64'(gen_seed), 64'(DEF));
    step();
    step();
    Reset = 1'b0;
    boot_check(DEF, 1'b0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      req      = NR'($urandom);
      cfg_load = ($urandom_range(0, 60) == 0);
      cfg_seed = 25'($urandom);
      Reset    = ($urandom_range(0, 500) == 0);
      step();
    end
    Reset    = 1'b0;
    cfg_load = 1'b0;
    req      = '0;
    step();
    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
